// File: rtl/display_pkg.sv
// Shared types and helpers for the display path: widths, color type,
// fade state encoding and the per-channel brightness scaler.
package display_pkg;

    localparam int H_BITS = 11;
    localparam int V_BITS = 10;

    typedef logic [11:0] color_t;

    typedef enum logic [1:0] {
        HIDDEN   = 2'd0,
        FADE_IN  = 2'd1,
        SHOWN    = 2'd2,
        FADE_OUT = 2'd3
    } fade_state_t;

    // Full level passes the channel through untouched so 15 is exact white.
    function automatic color_t scale_color(input color_t c, input logic [3:0] level);
        color_t r;
        r = '0;
        for (int i = 0; i < 3; i++) begin
            r[i*4 +: 4] = (level == 4'd15) ? c[i*4 +: 4]
                        : 4'(({4'b0, c[i*4 +: 4]} * {4'b0, level}) >> 4);
        end
        return r;
    endfunction

endpackage

// File: rtl/scaled_window_if.sv
// Bundle between the VGA timing generator / control side and the window block.
// update_in is a single-cycle strobe with no back-pressure; pending_out stays high
// from the cycle after a strobe until the next frame start applies it.
interface scaled_window_if;
    import display_pkg::*;

    logic [H_BITS-1:0] hcount_in;
    logic [V_BITS-1:0] vcount_in;
    logic [H_BITS-1:0] x_in;
    logic [V_BITS-1:0] y_in;
    logic [1:0]        scale_in;
    logic              update_in;
    logic              enable_in;
    color_t            pixel_out;
    logic              in_window_out;
    logic [7:0]        local_x_out;
    logic [7:0]        local_y_out;
    logic              pending_out;
    logic [3:0]        level_out;
    fade_state_t       state_out;

    modport master (
        output hcount_in, vcount_in, x_in, y_in, scale_in, update_in, enable_in,
        input  pixel_out, in_window_out, local_x_out, local_y_out, pending_out,
               level_out, state_out
    );

    modport slave (
        input  hcount_in, vcount_in, x_in, y_in, scale_in, update_in, enable_in,
        output pixel_out, in_window_out, local_x_out, local_y_out, pending_out,
               level_out, state_out
    );

endinterface

// File: rtl/scaled_window_fader.sv
// Brightness fade state machine; advances only on frame starts so a fade
// step never changes mid-frame.
module window_fader
    import display_pkg::*;
#(
    parameter int FADE_FRAMES = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        frame_start_in,
    input  logic        enable_in,
    output logic [3:0]  level_out,
    output fade_state_t state_out
);

    localparam int CW = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FADE_FRAMES - 1);

    fade_state_t   state_q;
    logic [3:0]    level_q;
    logic [CW-1:0] cnt_q;
    logic          step;

    assign step      = (cnt_q == CNT_LAST);
    assign level_out = level_q;
    assign state_out = state_q;

    // Direction reversals keep the level, so the end tests use <= / >= to
    // stay safe when a reversal happens right at an extreme.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= HIDDEN;
            level_q <= 4'd0;
            cnt_q   <= '0;
        end else if (frame_start_in) begin
            unique case (state_q)
                HIDDEN: begin
                    if (enable_in) begin
                        state_q <= FADE_IN;
                        cnt_q   <= '0;
                    end
                end
                FADE_IN: begin
                    if (!enable_in) begin
                        state_q <= FADE_OUT;
                        cnt_q   <= '0;
                    end else if (step) begin
                        cnt_q <= '0;
                        if (level_q >= 4'd14) begin
                            level_q <= 4'd15;
                            state_q <= SHOWN;
                        end else begin
                            level_q <= level_q + 4'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                SHOWN: begin
                    if (!enable_in) begin
                        state_q <= FADE_OUT;
                        cnt_q   <= '0;
                    end
                end
                FADE_OUT: begin
                    if (enable_in) begin
                        state_q <= FADE_IN;
                        cnt_q   <= '0;
                    end else if (step) begin
                        cnt_q <= '0;
                        if (level_q <= 4'd1) begin
                            level_q <= 4'd0;
                            state_q <= HIDDEN;
                        end else begin
                            level_q <= level_q - 4'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= HIDDEN;
            endcase
        end
    end

endmodule

// File: rtl/scaled_window.sv
// Scaled, bordered, fading display window with tear-free geometry updates
// and a two-stage pixel pipeline emitting source-pixel coordinates.
module scaled_window
    import display_pkg::*;
#(
    parameter int     WIDTH        = 160,
    parameter int     HEIGHT       = 144,
    parameter color_t COLOR        = 12'hFFF,
    parameter int     BORDER       = 2,
    parameter color_t BORDER_COLOR = 12'h888,
    parameter int     FADE_FRAMES  = 2
) (
    input  logic            clk_in,
    input  logic            rst_in,
    scaled_window_if.slave  bus
);

    logic frame_start;
    assign frame_start = (bus.hcount_in == '0) && (bus.vcount_in == '0);

    logic [H_BITS-1:0] shadow_x_q, shadow_x_d, act_x_q, act_x_d;
    logic [V_BITS-1:0] shadow_y_q, shadow_y_d, act_y_q, act_y_d;
    logic [1:0]        shadow_sc_q, shadow_sc_d, act_s_q, act_s_d;
    logic              pending_q, pending_d;

    logic        s1_fill_q, s1_fill_d, s1_border_q, s1_border_d;
    logic [11:0] s1_off_x_q, s1_off_x_d, s1_off_y_q, s1_off_y_d;
    logic [1:0]  s1_shift_q, s1_shift_d;

    color_t      pixel_q, pixel_d;
    logic        in_win_q, in_win_d;
    logic [7:0]  local_x_q, local_x_d, local_y_q, local_y_d;

    logic [3:0]  level;
    fade_state_t fade_state;

    // Apply decision uses the pending flag from before this cycle, so a strobe
    // landing on a frame start waits for the following frame.
    always_comb begin
        shadow_x_d  = shadow_x_q;
        shadow_y_d  = shadow_y_q;
        shadow_sc_d = shadow_sc_q;
        pending_d   = pending_q;
        act_x_d     = act_x_q;
        act_y_d     = act_y_q;
        act_s_d     = act_s_q;
        if (frame_start && pending_q) begin
            act_x_d   = shadow_x_q;
            act_y_d   = shadow_y_q;
            act_s_d   = (shadow_sc_q == 2'd3) ? 2'd2 : shadow_sc_q;
            pending_d = 1'b0;
        end
        if (bus.update_in) begin
            shadow_x_d  = bus.x_in;
            shadow_y_d  = bus.y_in;
            shadow_sc_d = bus.scale_in;
            pending_d   = 1'b1;
        end
    end

    logic [11:0] h12, v12, x12, y12, x_end, y_end, bx0, by0, bx1, by1;
    logic        region;

    always_comb begin
        h12   = {1'b0, bus.hcount_in};
        v12   = {2'b0, bus.vcount_in};
        x12   = {1'b0, act_x_q};
        y12   = {2'b0, act_y_q};
        x_end = x12 + (12'(WIDTH)  << act_s_q);
        y_end = y12 + (12'(HEIGHT) << act_s_q);
        bx0   = (x12 >= 12'(BORDER)) ? x12 - 12'(BORDER) : 12'd0;
        by0   = (y12 >= 12'(BORDER)) ? y12 - 12'(BORDER) : 12'd0;
        bx1   = x_end + 12'(BORDER);
        by1   = y_end + 12'(BORDER);
        s1_fill_d   = (h12 >= x12) && (h12 < x_end) && (v12 >= y12) && (v12 < y_end);
        region      = (h12 >= bx0) && (h12 < bx1) && (v12 >= by0) && (v12 < by1);
        s1_border_d = region && !s1_fill_d;
        s1_off_x_d  = h12 - x12;
        s1_off_y_d  = v12 - y12;
        s1_shift_d  = act_s_q;
    end

    always_comb begin
        in_win_d  = s1_fill_q;
        local_x_d = s1_fill_q ? 8'(s1_off_x_q >> s1_shift_q) : 8'd0;
        local_y_d = s1_fill_q ? 8'(s1_off_y_q >> s1_shift_q) : 8'd0;
        if (s1_fill_q)        pixel_d = scale_color(COLOR, level);
        else if (s1_border_q) pixel_d = scale_color(BORDER_COLOR, level);
        else                  pixel_d = '0;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            shadow_x_q  <= '0;
            shadow_y_q  <= '0;
            shadow_sc_q <= '0;
            pending_q   <= 1'b0;
            act_x_q     <= '0;
            act_y_q     <= '0;
            act_s_q     <= '0;
            s1_fill_q   <= 1'b0;
            s1_border_q <= 1'b0;
            s1_off_x_q  <= '0;
            s1_off_y_q  <= '0;
            s1_shift_q  <= '0;
            pixel_q     <= '0;
            in_win_q    <= 1'b0;
            local_x_q   <= '0;
            local_y_q   <= '0;
        end else begin
            shadow_x_q  <= shadow_x_d;
            shadow_y_q  <= shadow_y_d;
            shadow_sc_q <= shadow_sc_d;
            pending_q   <= pending_d;
            act_x_q     <= act_x_d;
            act_y_q     <= act_y_d;
            act_s_q     <= act_s_d;
            s1_fill_q   <= s1_fill_d;
            s1_border_q <= s1_border_d;
            s1_off_x_q  <= s1_off_x_d;
            s1_off_y_q  <= s1_off_y_d;
            s1_shift_q  <= s1_shift_d;
            pixel_q     <= pixel_d;
            in_win_q    <= in_win_d;
            local_x_q   <= local_x_d;
            local_y_q   <= local_y_d;
        end
    end

    window_fader #(.FADE_FRAMES(FADE_FRAMES)) u_fader (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .frame_start_in (frame_start),
        .enable_in      (bus.enable_in),
        .level_out      (level),
        .state_out      (fade_state)
    );

    assign bus.pixel_out     = pixel_q;
    assign bus.in_window_out = in_win_q;
    assign bus.local_x_out   = local_x_q;
    assign bus.local_y_out   = local_y_q;
    assign bus.pending_out   = pending_q;
    assign bus.level_out     = level;
    assign bus.state_out     = fade_state;

endmodule

// File: doc/scaled_window.md
Name: scaled_window

Overview:
- Registered, parametrised successor to the fixed 160x144 window generator in the VGA display path.
- Adds:
  - power-of-two integer scaling (1x/2x/4x)
  - frame-synchronous (tear-free) position/scale updates
  - optional colored border
  - brightness fade-in/fade-out state machine
- Emits source-pixel coordinates so a downstream framebuffer can be addressed.
- Sits between the VGA timing generator and the pixel mux.

Parameters:
- WIDTH, 160, source width in pixels (unscaled)
- HEIGHT, 144, source height in pixels (unscaled)
- COLOR, 12'hFFF, fill color when fully shown (4:4:4 RGB)
- BORDER, 2, border thickness in screen pixels; 0 disables border
- BORDER_COLOR, 12'h888, border color (also faded)
- FADE_FRAMES, 2, frames per brightness step (>=1)

Ports:
- clk_in  input  1  pixel clock
- rst_in  input  1  asynchronous, active-high reset
- hcount_in  input  11  current horizontal pixel
- vcount_in  input  10  current vertical line
- x_in  input  11  requested window left edge (screen px)
- y_in  input  10  requested window top edge (screen px)
- scale_in  input  2  requested scale: 0=1x, 1=2x, 2=4x, 3 treated as 4x
- update_in  input  1  one-cycle pulse: capture x_in/y_in/scale_in into shadow regs
- enable_in  input  1  level: 1 = show window (fade in), 0 = hide (fade out)
- pixel_out  output  12  faded fill/border color, 0 outside
- in_window_out  output  1  pixel lies in the fill region (not border)
- local_x_out  output  8  source column 0..WIDTH-1 (valid when in_window_out)
- local_y_out  output  8  source row 0..HEIGHT-1 (valid when in_window_out)
- pending_out  output  1  shadow update captured, not yet applied
- level_out  output  4  current brightness 0..15

Behaviour:
- Reset (async, rst_in=1):
  - all outputs 0
  - active x/y/scale = 0; shadow regs = 0
  - FSM = HIDDEN; level 0; frame step counter 0
- frame_start = (hcount_in==0 && vcount_in==0), evaluated combinationally on inputs.
- Shadow update:
  - update_in=1 loads the shadow regs and sets pending.
  - On frame_start with pending=1: active <= shadow, pending <= 0.
  - update_in and frame_start in the same cycle: shadow loads the new values; the pending state from before that cycle decides the apply (old shadow applied if it was pending); the new values apply at the next frame_start; pending_out=1 afterwards.
  - Repeated update_in before a frame_start: last one wins.
- Geometry (active regs, s = min(scale,2)):
  - W = WIDTH<<s, H = HEIGHT<<s; all compares at 12-bit width, no wrap.
  - Fill: x <= h < x+W and y <= v < y+H.
  - Border: inside [x-BORDER, x+W+BORDER) x [y-BORDER, y+H+BORDER) and not fill. The left/top extent clamps at 0 (no underflow when x<BORDER).
  - local_x = (h-x)>>s, local_y = (v-y)>>s; 0 when not fill.
- Pipeline: 2-cycle latency from hcount/vcount to pixel_out, in_window_out, local_x/y_out.
  - Stage 1 registers the compares and offsets.
  - Stage 2 registers shift, color select and fade.
  - Active regs switching on frame_start affect pixels entering the pipe from the next cycle onward.
- Fade FSM (advances only on frame_start):
  - Step counter counts frame_starts, 0..FADE_FRAMES-1; a "step" fires when it wraps.
  - HIDDEN (level 0): enable_in=1 -> FADE_IN.
  - FADE_IN: on step, level += 1; at 15 -> SHOWN. enable_in=0 -> FADE_OUT immediately (level kept, no jump).
  - SHOWN (level 15): enable_in=0 -> FADE_OUT.
  - FADE_OUT: on step, level -= 1; at 0 -> HIDDEN. enable_in=1 -> FADE_IN immediately.
  - Counter resets to 0 on every state change.
- Color fade, per 4-bit channel c:
  - out = c when level==15
  - else out = (c*level)>>4
  - level 0 -> pixel_out = 0 everywhere
  - in_window_out/local_* are independent of level.
- Reset mid-frame: outputs drop to 0 asynchronously; the pipeline refills, valid 2 cycles after release.

Decomposition:
- Package display_pkg:
  - fade_state_t enum {HIDDEN, FADE_IN, SHOWN, FADE_OUT}
  - color_t (12-bit) and H_BITS=11, V_BITS=10 constants
  - function scale_color(color_t, level)
- Sub-module window_fader: owns the FSM, step counter and level_out, driven by frame_start and enable_in.

Test Plan:
- Reset, then enable_in=1, FADE_FRAMES=2, scan 32 frames -> level_out steps 0->15, one step per 2 frames; pixel_out at (x,y) = 12'hFFF once SHOWN.
- SHOWN, x=100, y=50, scale=1: h=100,v=50 -> local 0,0; h=419,v=337 -> local 159,143; h=420 -> in_window_out=0, border color 12'h888 at h=420,421; h=422 -> pixel_out 0; all with 2-cycle latency.
- update_in mid-frame with x=200 -> pending_out=1, geometry unchanged until (0,0), then x=200 used and pending_out=0; update_in on the exact (0,0) cycle -> applies one frame later.
- x_in=0, y_in=0, BORDER=2 -> no border pixels at h>=2046 (no underflow); fill starts at h=0.
- Mid-fade-in at level 7, drop enable_in -> FADE_OUT from level 7 down to 0, HIDDEN; pixel_out 0 thereafter.
- Assert rst_in at mid-line -> all outputs 0 the same cycle, pending cleared, FSM HIDDEN.
